cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the 19-bit CPU. Sequences fetch/decode/execute/mem/writeback.
//  Drives the instruction register load strobe, PC update, register file write and data memory handshakes.
//  Sits between the instruction/data memories, the IR, the register file and the ALU. Owns no datapath registers.
// PARAMETERS
//  OPC_W     5    opcode width; matches IR bits [18:14]
//  HALT_OPC  16   opcode value that enters HALT
//  CNT_W     32   perf counter width; used only with CTRL_PERF_CNT_EN
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      IDLE->FETCH trigger; ignored in all other states
//  opcode     in   OPC_W  opcode from the IR; valid from DECODE onward
//  imem_req   out  1      instruction fetch request
//  imem_rdy   in   1      instruction word valid this cycle
//  load_IR    out  1      1-cycle IR load strobe
//  pc_inc     out  1      PC <= PC+1, 1-cycle strobe
//  pc_load    out  1      PC <= target selected by pc_sel, 1-cycle strobe
//  pc_sel     out  2      0=INC, 1=REL (PC+branch_offset), 2=ABS (addr_imm)
//  alu_op     out  4      ALU function select
//  alu_zero   in   1      ALU result==0; sampled in BR
//  rf_we      out  1      register file write enable, 1-cycle strobe
//  rf_wsel    out  2      write-data source: 0=ALU, 1=MEM, 2=LINK (PC)
//  dmem_req   out  1      data memory request
//  dmem_we    out  1      1=store, 0=load; valid while dmem_req=1
//  dmem_rdy   in   1      data memory transfer complete
//  busy       out  1      state not IDLE/HALT/TRAP
//  halted     out  1      in HALT
//  illegal    out  1      in TRAP (illegal opcode)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0. Takes effect mid-operation asynchronously (dmem_req/imem_req drop at once).
//  All control outputs are Moore, decoded from state + opcode. load_IR and pc_inc are Mealy on imem_rdy in FETCH.
//  IDLE:   start=1 -> FETCH.
//  FETCH:  imem_req=1 held until imem_rdy=1. That cycle: load_IR=1, pc_inc=1, go to DECODE. No timeout.
//  DECODE: opcode 0-9 -> EXEC. 10(LD), 11(ST) -> MEM. 12(BEQ), 13(BNE) -> EXEC.
//          14(JMP): pc_load=1, pc_sel=2 -> FETCH.
//          15(CALL): pc_load=1, pc_sel=2, rf_we=1, rf_wsel=2 -> FETCH.
//          HALT_OPC -> HALT. Any other opcode -> TRAP.
//  EXEC:   ALU ops: alu_op=opcode[3:0] -> WB. Branch: alu_op=4'd1 (SUB) -> BR.
//  BR:     taken = alu_zero XOR (opcode==13). If taken: pc_load=1, pc_sel=1. Always -> FETCH.
//          Offset is relative to the already-incremented PC.
//  MEM:    dmem_req=1, dmem_we=(opcode==11), both held until dmem_rdy. On rdy: LD -> WB, ST -> FETCH.
//  WB:     rf_we=1; rf_wsel=1 for LD, else 0 -> FETCH.
//  HALT/TRAP: terminal until rst. start is ignored. halted/illegal are level outputs.
//  Latency (zero-wait memories): ALU 4, LD 4, ST 3, BEQ/BNE 4, JMP/CALL 2 cycles. Each memory wait adds 1.
//  imem_rdy/dmem_rdy may be high in the first cycle req is high (0-wait). rdy outside its state is ignored.
//  pc_inc and pc_load are never both 1. rf_we is never 1 while dmem_req=1.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//   - Adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W], both reset to 0.
//   - cycle_cnt counts every cycle with busy=1. instr_cnt counts each DECODE cycle.
//   - Both saturate at all-ones.
//  Not defined: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package cpu19_pkg: opcode localparams (OP_ADD..OP_JMP, OP_CALL, OP_HALT); state enum codes
//   (IDLE, FETCH, DECODE, EXEC, BR, MEM, WB, HALT, TRAP); pc_sel/rf_wsel encodings; ALU_SUB.
//  Sub-module op_class_decode: combinational opcode -> {is_alu, is_ld, is_st, is_br, is_jmp, is_call, is_halt, is_ill}.
//  Top holds the state register, next-state logic and output decode.
// TESTING
//  1. rst high, start=1 -> all outputs 0, state IDLE. Release rst, start=1 -> imem_req=1 next cycle.
//  2. ADD (op 0), imem_rdy tied 1 -> load_IR at c1, rf_we=1/rf_wsel=0 at c4, imem_req again at c5.
//  3. LD (op 10), dmem_rdy low 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles, then rf_we=1, rf_wsel=1.
//  4. BEQ with alu_zero=1 -> pc_load=1, pc_sel=1 in BR. BNE with alu_zero=1 -> no pc_load, back to FETCH.
//  5. CALL (op 15) -> pc_load=1, pc_sel=2, rf_we=1, rf_wsel=2 same cycle. Op 20 -> illegal=1, busy=0, sticky.
//  6. rst pulsed mid-MEM -> dmem_req falls before the next clk edge. With CTRL_PERF_CNT_EN, ADD gives instr_cnt=1, cycle_cnt=4.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the 19-bit CPU control unit: opcodes, FSM states,
// PC / write-back source encodings and the opcode class record.
package cpu19_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_XOR  = 4;
    localparam int unsigned OP_SHL  = 5;
    localparam int unsigned OP_SHR  = 6;
    localparam int unsigned OP_SRA  = 7;
    localparam int unsigned OP_MOV  = 8;
    localparam int unsigned OP_CMP  = 9;
    localparam int unsigned OP_LD   = 10;
    localparam int unsigned OP_ST   = 11;
    localparam int unsigned OP_BEQ  = 12;
    localparam int unsigned OP_BNE  = 13;
    localparam int unsigned OP_JMP  = 14;
    localparam int unsigned OP_CALL = 15;
    localparam int unsigned OP_HALT = 16;

    localparam int unsigned OP_ALU_LAST = OP_CMP;

    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, BR, MEM, WB, HALT, TRAP
    } state_t;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_REL = 2'd1,
        PC_ABS = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WS_ALU  = 2'd0,
        WS_MEM  = 2'd1,
        WS_LINK = 2'd2
    } rf_wsel_t;

    typedef struct packed {
        logic is_alu;
        logic is_ld;
        logic is_st;
        logic is_br;
        logic is_jmp;
        logic is_call;
        logic is_halt;
        logic is_ill;
    } op_class_t;

    // BNE inverts the sense of the ALU zero flag
    function automatic logic branch_taken(input logic zero, input logic is_bne);
        return zero ^ is_bne;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bus between cpu_ctrl_fsm (master) and the memories/datapath (slave).
interface cpu_ctrl_fsm_if #(
    parameter int unsigned OPC_W = 5
);
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             imem_req;
    logic             imem_rdy;
    logic             load_IR;
    logic             pc_inc;
    logic             pc_load;
    logic [1:0]       pc_sel;
    logic [3:0]       alu_op;
    logic             alu_zero;
    logic             rf_we;
    logic [1:0]       rf_wsel;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_rdy;
    logic             busy;
    logic             halted;
    logic             illegal;

    modport master (
        input  start, opcode, imem_rdy, alu_zero, dmem_rdy,
        output imem_req, load_IR, pc_inc, pc_load, pc_sel, alu_op,
               rf_we, rf_wsel, dmem_req, dmem_we, busy, halted, illegal
    );

    modport slave (
        output start, opcode, imem_rdy, alu_zero, dmem_rdy,
        input  imem_req, load_IR, pc_inc, pc_load, pc_sel, alu_op,
               rf_we, rf_wsel, dmem_req, dmem_we, busy, halted, illegal
    );
endinterface

// File: rtl/cpu_ctrl_fsm_op_class_decode.sv
// Combinational opcode classifier; exactly one class bit is set per opcode.
module op_class_decode
    import cpu19_pkg::*;
#(
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned HALT_OPC = 16
) (
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls
);
    logic [31:0] op_val;

    assign op_val = 32'(opcode);

    // HALT_OPC is checked first so a relocated halt code overrides the fixed map
    always_comb begin
        cls = '0;
        if (op_val == HALT_OPC)                         cls.is_halt = 1'b1;
        else if (op_val <= OP_ALU_LAST)                 cls.is_alu  = 1'b1;
        else if (op_val == OP_LD)                       cls.is_ld   = 1'b1;
        else if (op_val == OP_ST)                       cls.is_st   = 1'b1;
        else if (op_val == OP_BEQ || op_val == OP_BNE)  cls.is_br   = 1'b1;
        else if (op_val == OP_JMP)                      cls.is_jmp  = 1'b1;
        else if (op_val == OP_CALL)                     cls.is_call = 1'b1;
        else                                            cls.is_ill  = 1'b1;
    end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the 19-bit CPU (fetch/decode/exec/mem/wb).
// Optional perf counters cycle_cnt/instr_cnt are enabled by CTRL_PERF_CNT_EN.
module cpu_ctrl_fsm
    import cpu19_pkg::*;
#(
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned HALT_OPC = 16
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    cpu_ctrl_fsm_if.master   bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);
    state_t    state, state_next;
    op_class_t cls;
    logic      is_bne;

    logic       imem_req, ld_ir, pc_inc, pc_load;
    logic [1:0] pc_sel;
    logic [3:0] alu_op;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       dmem_req, dmem_we;
    logic       busy, halted, illegal;

    op_class_decode #(
        .OPC_W    (OPC_W),
        .HALT_OPC (HALT_OPC)
    ) u_dec (
        .opcode (bus.opcode),
        .cls    (cls)
    );

    assign is_bne = (32'(bus.opcode) == OP_BNE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ld_ir      = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_sel     = PC_INC;
        alu_op     = '0;
        rf_we      = 1'b0;
        rf_wsel    = WS_ALU;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        busy       = (state != IDLE) && (state != HALT) && (state != TRAP);
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_rdy) begin
                    ld_ir      = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (cls.is_ill) begin
                    state_next = TRAP;
                end else if (cls.is_halt) begin
                    state_next = HALT;
                end else if (cls.is_alu || cls.is_br) begin
                    state_next = EXEC;
                end else if (cls.is_ld || cls.is_st) begin
                    state_next = MEM;
                end else if (cls.is_jmp) begin
                    pc_load    = 1'b1;
                    pc_sel     = PC_ABS;
                    state_next = FETCH;
                end else if (cls.is_call) begin
                    pc_load    = 1'b1;
                    pc_sel     = PC_ABS;
                    rf_we      = 1'b1;
                    rf_wsel    = WS_LINK;
                    state_next = FETCH;
                end
            end
            EXEC: begin
                if (cls.is_br) begin
                    alu_op     = ALU_SUB;
                    state_next = BR;
                end else begin
                    alu_op     = bus.opcode[3:0];
                    state_next = WB;
                end
            end
            BR: begin
                if (branch_taken(bus.alu_zero, is_bne)) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_REL;
                end
                state_next = FETCH;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.is_st;
                if (bus.dmem_rdy) state_next = cls.is_st ? FETCH : WB;
            end
            WB: begin
                rf_we      = 1'b1;
                rf_wsel    = cls.is_ld ? WS_MEM : WS_ALU;
                state_next = FETCH;
            end
            HALT: halted  = 1'b1;
            TRAP: illegal = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.load_IR  = ld_ir;
    assign bus.pc_inc   = pc_inc;
    assign bus.pc_load  = pc_load;
    assign bus.pc_sel   = pc_sel;
    assign bus.alu_op   = alu_op;
    assign bus.rf_we    = rf_we;
    assign bus.rf_wsel  = rf_wsel;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.busy     = busy;
    assign bus.halted   = halted;
    assign bus.illegal  = illegal;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 1'b1;
            if ((state == DECODE) && (instr_cnt != '1))
                instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule
